// File: rtl/fxpt_pkg.sv
// Shared Q12.12 fixed-point types and constants for the divider front end.
package fxpt_pkg;

  localparam int FXPT_W    = 24;
  localparam int FXPT_FRAC = 12;

  typedef logic signed [FXPT_W-1:0] fxpt_t;

  localparam fxpt_t FXPT_MAX = 24'h7FFFFF;
  localparam fxpt_t FXPT_MIN = 24'h800000;

  // DRAIN waits out stale divider results, because the divider itself is never reset.
  typedef enum logic {
    ST_DRAIN = 1'b0,
    ST_RUN   = 1'b1
  } issue_state_e;

endpackage

// File: rtl/fxpt_sync_fifo.sv
// First-word-fall-through synchronous FIFO with asynchronous active-high reset.
// Writes while full and reads while empty are ignored.
module fxpt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             full;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign dout  = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[ADDR_W-1:0]] <= din;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fxpt_div_issue.sv
// Tagged, credit-based front end for the fixed-latency fxpt_div divider.
// Optional statistics counters are built when FXPT_DIV_ISSUE_STATS_EN is defined.
module fxpt_div_issue
  import fxpt_pkg::*;
#(
  parameter int DATA_W       = FXPT_W,
  parameter int FRAC_W       = FXPT_FRAC,
  parameter int TAG_W        = 8,
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              div_divisor_tvalid,
  output logic              div_dividend_tvalid,
  output logic [DATA_W-1:0] div_divisor,
  output logic [DATA_W-1:0] div_dividend,
  input  logic              div_tvalid,
  input  logic [DATA_W-1:0] div_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_dz,
  output logic              busy,
  output logic              err_orphan,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_dz
);

  localparam int CRED_W  = $clog2(DEPTH + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int TAGQ_W  = TAG_W + 3;
  localparam int RESQ_W  = DATA_W + TAG_W + 1;

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-FRAC_W-1){1'b1}}, {FRAC_W{1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-FRAC_W-1){1'b0}}, {FRAC_W{1'b0}}};

  issue_state_e       state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CRED_W-1:0]  credits;
  logic               issue_vld;

  logic               accept;
  logic               out_fire;
  logic               ret;
  logic               orphan;

  logic [TAGQ_W-1:0]  tag_din;
  logic [TAGQ_W-1:0]  tag_head;
  logic               tag_empty;
  logic [RESQ_W-1:0]  res_head;
  logic               res_empty;
  logic [DATA_W-1:0]  res_sat;

  assign in_ready = (state == ST_RUN) && (credits != '0);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign ret      = (state == ST_RUN) && div_tvalid && !tag_empty;
  assign orphan   = (state == ST_RUN) && div_tvalid && tag_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_DRAIN;
      drain_cnt  <= '0;
      err_orphan <= 1'b0;
    end else begin
      case (state)
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state <= ST_RUN;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (orphan) begin
            err_orphan <= 1'b1;
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

  // A credit covers a request from acceptance until its result leaves the output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_W'(DEPTH);
    end else begin
      if (accept && !out_fire) begin
        credits <= credits - 1'b1;
      end else if (out_fire && !accept && (credits != CRED_W'(DEPTH))) begin
        credits <= credits + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_vld    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      issue_vld <= accept;
      if (accept) begin
        div_dividend <= in_dividend;
        div_divisor  <= in_divisor;
      end
    end
  end

  assign div_dividend_tvalid = issue_vld;
  assign div_divisor_tvalid  = issue_vld;
  assign busy                = (credits != CRED_W'(DEPTH)) || issue_vld;

  assign tag_din = {in_tag, (in_divisor == '0), in_dividend[DATA_W-1], (in_dividend == '0)};

  fxpt_sync_fifo #(
    .WIDTH (TAGQ_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (tag_din),
    .pop   (ret),
    .dout  (tag_head),
    .empty (tag_empty)
  );

  // Zero divisors still go through the divider; the quotient is replaced here.
  always_comb begin
    res_sat = div_result;
    if (tag_head[2]) begin
      if (tag_head[0]) begin
        res_sat = '0;
      end else if (tag_head[1]) begin
        res_sat = SAT_MIN;
      end else begin
        res_sat = SAT_MAX;
      end
    end
  end

  fxpt_sync_fifo #(
    .WIDTH (RESQ_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret),
    .din   ({res_sat, tag_head[TAGQ_W-1:3], tag_head[2]}),
    .pop   (out_fire),
    .dout  (res_head),
    .empty (res_empty)
  );

  assign out_valid                    = !res_empty;
  assign {out_result, out_tag, out_dz} = res_head;

`ifdef FXPT_DIV_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
      stat_dz     <= '0;
    end else begin
      if (accept) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (accept && (in_divisor == '0)) begin
        stat_dz <= stat_dz + 32'd1;
      end
      if ((state == ST_RUN) && in_valid && !in_ready) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
  assign stat_dz     = '0;
`endif

endmodule

// File: tb/tb_fxpt_div_issue.sv
// Scoreboard bench for fxpt_div_issue with a 28-cycle, never-reset divider model.
module tb_fxpt_div_issue;

  localparam int DATA_W = 24;
  localparam int TAG_W  = 8;
  localparam int DEPTH  = 16;
  localparam int LAT    = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_dividend;
  logic [DATA_W-1:0] in_divisor;
  logic [TAG_W-1:0]  in_tag;
  logic              div_divisor_tvalid;
  logic              div_dividend_tvalid;
  logic [DATA_W-1:0] div_divisor;
  logic [DATA_W-1:0] div_dividend;
  logic              div_tvalid;
  logic [DATA_W-1:0] div_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_dz;
  logic              busy;
  logic              err_orphan;
  logic [31:0]       stat_issued;
  logic [31:0]       stat_stall;
  logic [31:0]       stat_dz;
  logic              inject;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  tag;
    logic              dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_issued = 0;
  int   n_dz     = 0;
  int   n_stall  = 0;

  bit              pipe_v [LAT];
  bit [DATA_W-1:0] pipe_d [LAT];

  always #5 clk = ~clk;

  fxpt_div_issue dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_dividend         (in_dividend),
    .in_divisor          (in_divisor),
    .in_tag              (in_tag),
    .div_divisor_tvalid  (div_divisor_tvalid),
    .div_dividend_tvalid (div_dividend_tvalid),
    .div_divisor         (div_divisor),
    .div_dividend        (div_dividend),
    .div_tvalid          (div_tvalid),
    .div_result          (div_result),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_result          (out_result),
    .out_tag             (out_tag),
    .out_dz              (out_dz),
    .busy                (busy),
    .err_orphan          (err_orphan),
    .stat_issued         (stat_issued),
    .stat_stall          (stat_stall),
    .stat_dz             (stat_dz)
  );

  function automatic logic [DATA_W-1:0] quot(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [35:0] num;
    logic signed [35:0] den;
    logic signed [35:0] q;
    num = {{12{a[23]}}, a};
    num = num <<< 12;
    den = {{12{b[23]}}, b};
    if (b == '0) return '0;
    q = num / den;
    return q[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] expect_res(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (b != '0) return quot(a, b);
    if (a == '0) return 24'h000000;
    return a[23] ? 24'h800000 : 24'h7FFFFF;
  endfunction

  // Divider model: no reset, fixed latency, keeps running through rst.
  always @(posedge clk) begin
    pipe_v[0] <= div_dividend_tvalid;
    pipe_d[0] <= quot(div_dividend, div_divisor);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign div_tvalid = pipe_v[LAT-1] | inject;
  assign div_result = pipe_d[LAT-1];

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (div_dividend_tvalid || div_divisor_tvalid) begin
        total++;
        if (div_dividend_tvalid !== div_divisor_tvalid) begin
          bad++;
          $display("[TB] FAIL strobe_pair: dividend_tvalid=%b divisor_tvalid=%b", div_dividend_tvalid, div_divisor_tvalid);
        end
      end
      if (out_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_out: got out_valid=1 tag=%0d, expected no result", out_tag);
        end else if (out_ready) begin
          mon_e = sb.pop_front();
          if ({out_result, out_tag, out_dz} !== {mon_e.res, mon_e.tag, mon_e.dz}) begin
            bad++;
            $display("[TB] FAIL result: got res=%h tag=%0d dz=%b, expected res=%h tag=%0d dz=%b",
                     out_result, out_tag, out_dz, mon_e.res, mon_e.tag, mon_e.dz);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] t);
    int waitc = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    while (!in_ready && waitc < 300) begin
      n_stall++;
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: tag %0d not accepted after %0d cycles", t, waitc);
    end else begin
      sb.push_back('{res: expect_res(a, b), tag: t, dz: (b == '0)});
      n_issued++;
      if (b == '0) n_dz++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy) && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0 || busy) begin
      bad++;
      $display("[TB] FAIL idle_timeout: got pending=%0d busy=%b, expected 0/0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    int c = 0;
    int lat = 0;
    rst = 1'b1; inject = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_dividend = 24'h003000; in_divisor = 24'h002000; in_tag = 8'd5;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, err_orphan, div_dividend_tvalid, out_result, out_tag, out_dz} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got in_ready=%b out_valid=%b busy=%b orphan=%b strobe=%b res=%h, expected all 0",
               in_ready, out_valid, busy, err_orphan, div_dividend_tvalid, out_result);
    end
    rst = 1'b0;
    while (!in_ready && c < 100) begin
      c++;
      @(negedge clk);
    end
    total++;
    if (c != 32) begin
      bad++;
      $display("[TB] FAIL drain_len: got %0d cycles with in_ready=0, expected 32", c);
    end
    send(24'h003000, 24'h002000, 8'd5);
    // The handshake cycle plus 29 more makes 1 + 28 + 1 cycles to out_valid.
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 29 || out_result !== 24'h001800 || out_tag !== 8'd5) begin
      bad++;
      $display("[TB] FAIL first_result: got lat=%0d res=%h tag=%0d, expected lat=29 res=001800 tag=5", lat, out_result, out_tag);
    end
    wait_idle();
  endtask

  task automatic test_ordering();
    int s0;
    out_ready = 1'b0;
    s0 = n_stall;
    for (int i = 0; i < 16; i++) begin
      send(24'((i + 1) << 12), 24'h001000 + 24'(i << 8), 8'(i));
    end
    total++;
    if (in_ready !== 1'b0 || n_stall != s0) begin
      bad++;
      $display("[TB] FAIL full_credit: got in_ready=%b stalls=%0d, expected in_ready=0 stalls=0", in_ready, n_stall - s0);
    end
    fork
      send(24'h011000, 24'h002000, 8'd16);
      begin
        repeat (40) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'd0) begin
          bad++;
          $display("[TB] FAIL buffered_head: got in_ready=%b out_valid=%b tag=%0d, expected 0/1/0", in_ready, out_valid, out_tag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL credit_return: got in_ready=%b, expected 1", in_ready);
        end
      end
    join
    wait_idle();
  endtask

  task automatic test_dz();
    int c = 0;
    out_ready = 1'b0;
    send(24'h001000, 24'h000000, 8'd40);
    send(24'hFFF000, 24'h000000, 8'd41);
    send(24'h000000, 24'h000000, 8'd42);
    while (!out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (out_result !== 24'h7FFFFF || out_dz !== 1'b1 || out_tag !== 8'd40) begin
      bad++;
      $display("[TB] FAIL dz_pos: got res=%h dz=%b tag=%0d, expected 7fffff/1/40", out_result, out_dz, out_tag);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int s0;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    out_ready = 1'b1;
    s0 = n_stall;
    for (int i = 0; i < 200; i++) begin
      a = 24'($urandom);
      b = (i % 37 == 3) ? 24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
      send(a, b, 8'(i));
      if (i == 15) begin
        total++;
        if (n_stall != s0) begin
          bad++;
          $display("[TB] FAIL burst_rate: got %0d stall cycles in first 16 requests, expected 0", n_stall - s0);
        end
      end
    end
    wait_idle();
    total++;
    if (err_orphan !== 1'b0) begin
      bad++;
      $display("[TB] FAIL steady_orphan: got err_orphan=%b, expected 0", err_orphan);
    end
  endtask

  task automatic test_reset_mid();
    int ov = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(24'((i + 3) << 12), 24'h001800, 8'(100 + i));
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    n_issued = 0; n_dz = 0; n_stall = 0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    total++;
    if (ov != 0 || err_orphan !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid: got out_valid_cycles=%0d orphan=%b busy=%b in_ready=%b, expected 0/0/0/1",
               ov, err_orphan, busy, in_ready);
    end
  endtask

  task automatic test_orphan();
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (err_orphan !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL orphan: got err_orphan=%b out_valid=%b, expected 1/0", err_orphan, out_valid);
    end
    send(24'h002000, 24'h001000, 8'd60);
    send(24'h005000, 24'h000000, 8'd61);
    wait_idle();
    total++;
    if (err_orphan !== 1'b1) begin
      bad++;
      $display("[TB] FAIL orphan_sticky: got err_orphan=%b, expected 1", err_orphan);
    end
  endtask

  task automatic test_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(24'h004000, (i % 4 == 0) ? 24'h0 : 24'h002000, 8'(i));
    end
    fork
      send(24'h004000, 24'h000000, 8'd16);
      begin
        repeat (20) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_idle();
`ifdef FXPT_DIV_ISSUE_STATS_EN
    total++;
    if (stat_issued !== 32'(n_issued) || stat_dz !== 32'(n_dz) || stat_stall !== 32'(n_stall)) begin
      bad++;
      $display("[TB] FAIL stats: got issued=%0d dz=%0d stall=%0d, expected %0d/%0d/%0d",
               stat_issued, stat_dz, stat_stall, n_issued, n_dz, n_stall);
    end
`else
    total++;
    if ({stat_issued, stat_dz, stat_stall} !== '0) begin
      bad++;
      $display("[TB] FAIL stats_off: got issued=%0d dz=%0d stall=%0d, expected 0/0/0", stat_issued, stat_dz, stat_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_dz();
    test_back_to_back();
    test_reset_mid();
    test_orphan();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
